uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 11-bit frames (start, 8 data bits MSB first, even parity, stop)
// with a one-entry holding buffer so consecutive frames can follow with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            bit_end;
  logic            load;
  logic            direct;
  logic [7:0]      load_byte;

  assign accept  = tx_start & ~buf_full_q;
  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    sh_d       = sh_q;
    par_d      = par_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    direct     = 1'b0;
    load_byte  = tx_data;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (buf_full_q) begin
          load       = 1'b1;
          load_byte  = buf_q;
          buf_full_d = 1'b0;
        end else if (accept) begin
          load   = 1'b1;
          direct = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[7];
          sh_d    = {sh_q[6:0], 1'b0};
        end
      end
      DATA: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            tx_d = sh_q[7];
            sh_d = {sh_q[6:0], 1'b0};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Next frame's start bit begins on the very next cycle: buffered byte first,
          // otherwise a request arriving on this same edge goes straight to the shifter.
          if (buf_full_q) begin
            load       = 1'b1;
            load_byte  = buf_q;
            buf_full_d = 1'b0;
          end else if (accept) begin
            load   = 1'b1;
            direct = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (accept && !direct) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (load) begin
      state_d = START;
      sh_d    = load_byte;
      par_d   = ^load_byte;
      idx_d   = '0;
      cnt_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_ready = ~buf_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle frame-position reference model plus a mid-bit
// sampling reference receiver, directed frames and randomized traffic.
module tb_uart_tx;
  localparam int CPB   = 27;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_ready, tx, tx_busy, tx_done;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_3125 (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: frame position counted in cycles, line value from position / CPB.
  bit         m_active = 0;
  bit         m_qfull  = 0;
  bit         m_done   = 0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = '0;
  logic [7:0] m_qbyte  = '0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[8 - k];
    if (k == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit acc, used;
    if (rst) begin
      m_active = 0; m_qfull = 0; m_done = 0; m_pos = 0;
    end else begin
      acc    = tx_start && !m_qfull;
      used   = 0;
      m_done = m_active && (m_pos == FRAME - 1);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) begin
          if (m_qfull) begin
            m_byte = m_qbyte; m_qfull = 0; m_pos = 0;
          end else if (acc) begin
            m_byte = tx_data; m_pos = 0; used = 1;
          end else begin
            m_active = 0;
          end
        end
      end else if (acc) begin
        m_active = 1; m_byte = tx_data; m_pos = 0; used = 1;
      end
      if (acc && !used) begin
        m_qfull = 1; m_qbyte = tx_data;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_tx;
    exp_tx = m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1;
    check("outs{tx,busy,ready,done}", {28'd0, tx, tx_busy, tx_ready, tx_done},
          {28'd0, exp_tx, m_active, !m_qfull, m_done});
  end

  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int prev_done_cyc = 0;
  int last_done_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    acc_cyc  = cyc;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
    check("ready_timeout", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (tx_busy && k < 2000) begin @(negedge clk); k++; end
    check("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic rx_frame(output logic [7:0] b, output logic p, output logic ok);
    logic [10:0] f;
    int k = 0;
    f = '1;
    while (tx !== 1'b0 && k < 4000) begin @(negedge clk); k++; end
    if (k < 4000) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
        f[10 - i] = tx;
        if (i < 10) repeat (CPB) @(negedge clk);
      end
    end
    b  = f[9:2];
    p  = f[1];
    ok = (k < 4000) && (f[10] == 1'b0) && (f[0] == 1'b1);
  endtask

  task automatic xfer(input logic [7:0] d);
    logic [7:0] b;
    logic p, ok;
    fork
      rx_frame(b, p, ok);
      send(d);
    join
    check("rx_byte", {24'd0, b}, {24'd0, d});
    check("rx_parity", {31'd0, p}, {31'd0, ^d});
    check("rx_format", {31'd0, ok}, 32'd1);
  endtask

  logic [7:0] sent [11];
  logic [7:0] b1, b2;
  logic       p1, p2, ok1, ok2;
  int         d0;

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x41 from idle; tx_done appears in cycle 298 counting the accept edge's cycle as 1
    xfer(8'h41);
    begin
      int k = 0;
      while (!tx_done && k < 400) begin @(negedge clk); k++; end
      check("done_latency", cyc - acc_cyc + 1, 298);
    end
    wait_idle();
    xfer(8'h07);
    wait_idle();
    @(negedge clk);

    // Buffered second byte during DATA, extra request while buffer full is ignored
    d0 = done_cnt;
    fork
      begin
        rx_frame(b1, p1, ok1);
        rx_frame(b2, p2, ok2);
      end
      begin
        send(8'h48);
        repeat (60) @(negedge clk);
        send(8'h69);
        check("buf_ready_low", {31'd0, tx_ready}, 32'd0);
        repeat (20) @(negedge clk);
        send(8'hFF);
        check("full_ready_low", {31'd0, tx_ready}, 32'd0);
      end
    join
    wait_idle();
    @(negedge clk);
    check("b2b_byte0", {24'd0, b1}, 32'h48);
    check("b2b_byte1", {24'd0, b2}, 32'h69);
    check("b2b_fmt", {30'd0, ok1, ok2}, 32'd3);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_done_gap", last_done_cyc - prev_done_cyc, FRAME);
    repeat (40) @(negedge clk);
    check("ignored_ff", {31'd0, tx_busy}, 32'd0);

    // Reset during the 4th data bit of 0x55, then 0x3F right after release
    d0 = done_cnt;
    send(8'h55);
    repeat (115) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    xfer(8'h3F);
    wait_idle();
    @(negedge clk);
    check("abort_done_cnt", done_cnt - d0, 1);

    // 11 random bytes back-to-back through the reference receiver
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 11; i++) begin
          wait_ready();
          sent[i] = 8'($urandom);
          send(sent[i]);
        end
      end
      begin
        for (int j = 0; j < 11; j++) begin
          logic [7:0] rb;
          logic rp, rok;
          rx_frame(rb, rp, rok);
          check("rand_byte", {24'd0, rb}, {24'd0, sent[j]});
          check("rand_parity", {31'd0, rp}, {31'd0, ^sent[j]});
          check("rand_format", {31'd0, rok}, 32'd1);
        end
      end
    join
    wait_idle();
    @(negedge clk);
    check("rand_done_cnt", done_cnt - d0, 11);

    // Free-running random traffic with occasional resets; per-cycle model does the checking
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      tx_start = ($urandom_range(0, 99) < 6);
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
